// File: rtl/picosoc_bus_pkg.sv
// Shared types and defaults for the picosoc_bus single-master interconnect.
// Build option PICOSOC_BUS_TIMEOUT_EN (see picosoc_bus.sv) does not affect this package.
package picosoc_bus_pkg;

  localparam int          MAX_NSLAVES   = 16;
  localparam int          IDX_W         = 4;
  localparam logic [31:0] DEF_ERR_RDATA = 32'hDEAD_BEEF;
  localparam logic [31:0] DEF_SLV_MASK  = 32'hFF00_0000;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  // Slave i occupies the 16 MB window starting at i<<24.
  function automatic logic [MAX_NSLAVES*32-1:0] def_slv_base(input int n);
    logic [MAX_NSLAVES*32-1:0] r;
    r = '0;
    for (int i = 0; i < MAX_NSLAVES; i++) begin
      if (i < n) r[32*i +: 32] = 32'(i) << 24;
    end
    return r;
  endfunction

endpackage

// File: rtl/picosoc_bus_decode.sv
// Combinational address decoder: one-hot hit, hit index and miss flag.
// Lowest-numbered slave wins when windows overlap.
module picosoc_bus_decode
  import picosoc_bus_pkg::*;
#(
  parameter int                    NSLAVES  = 4,
  parameter logic [NSLAVES*32-1:0] SLV_BASE = (NSLAVES*32)'(def_slv_base(NSLAVES)),
  parameter logic [NSLAVES*32-1:0] SLV_MASK = {NSLAVES{DEF_SLV_MASK}}
) (
  input  logic [31:0]        i_addr,
  output logic [NSLAVES-1:0] o_hit,
  output logic [IDX_W-1:0]   o_idx,
  output logic               o_miss
);

  // Scanning downward lets the lowest matching index overwrite the others.
  always_comb begin
    o_hit  = '0;
    o_idx  = '0;
    o_miss = 1'b1;
    for (int i = NSLAVES - 1; i >= 0; i--) begin
      if ((i_addr & SLV_MASK[32*i +: 32]) == SLV_BASE[32*i +: 32]) begin
        o_hit    = '0;
        o_hit[i] = 1'b1;
        o_idx    = IDX_W'(i);
        o_miss   = 1'b0;
      end
    end
  end

endmodule

// File: rtl/picosoc_bus.sv
// Single-master to NSLAVES-slave bus bridge with sticky error capture.
// Define PICOSOC_BUS_TIMEOUT_EN to abort slave accesses after TIMEOUT_CYCLES.
//
// state  | meaning
// IDLE   | waiting for m_valid; request registered onto s_* and decoded
// ACCESS | s_valid[sel] held until s_ready[sel] (or timeout)
// RESP   | m_ready pulse; a decode miss spends one extra cycle here first
module picosoc_bus
  import picosoc_bus_pkg::*;
#(
  parameter int                    NSLAVES        = 4,
  parameter logic [NSLAVES*32-1:0] SLV_BASE       = (NSLAVES*32)'(def_slv_base(NSLAVES)),
  parameter logic [NSLAVES*32-1:0] SLV_MASK       = {NSLAVES{DEF_SLV_MASK}},
  parameter int                    TIMEOUT_CYCLES = 255,
  parameter logic [31:0]           ERR_RDATA      = DEF_ERR_RDATA
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic                    i_m_valid,
  output logic                    o_m_ready,
  input  logic [31:0]             i_m_addr,
  input  logic [31:0]             i_m_wdata,
  input  logic [3:0]              i_m_wstrb,
  output logic [31:0]             o_m_rdata,
  output logic [NSLAVES-1:0]      o_s_valid,
  input  logic [NSLAVES-1:0]      i_s_ready,
  output logic [31:0]             o_s_addr,
  output logic [31:0]             o_s_wdata,
  output logic [3:0]              o_s_wstrb,
  input  logic [NSLAVES*32-1:0]   i_s_rdata,
  output logic                    o_err_valid,
  output logic [31:0]             o_err_addr,
  input  logic                    i_err_clr
);

  if (NSLAVES < 1 || NSLAVES > MAX_NSLAVES) begin : g_bad_nslaves
    $error("picosoc_bus: NSLAVES out of range 1..16");
  end
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("picosoc_bus: TIMEOUT_CYCLES out of range 1..65535");
  end

  state_e               r_state;
  logic                 r_m_ready;
  logic [31:0]          r_m_rdata;
  logic [NSLAVES-1:0]   r_s_valid;
  logic [31:0]          r_s_addr;
  logic [31:0]          r_s_wdata;
  logic [3:0]           r_s_wstrb;
  logic [IDX_W-1:0]     r_sel;
  logic                 r_miss_hold;
  logic                 r_err_valid;
  logic [31:0]          r_err_addr;

  logic [NSLAVES-1:0]   w_hit;
  logic [IDX_W-1:0]     w_idx;
  logic                 w_miss;
  logic                 w_sel_ready;
  logic [31:0]          w_sel_rdata;
  logic                 w_tmo;
  logic                 w_err_raise;
  logic [31:0]          w_err_addr;

  picosoc_bus_decode #(
    .NSLAVES  (NSLAVES),
    .SLV_BASE (SLV_BASE),
    .SLV_MASK (SLV_MASK)
  ) u_decode (
    .i_addr (i_m_addr),
    .o_hit  (w_hit),
    .o_idx  (w_idx),
    .o_miss (w_miss)
  );

  // s_valid is one-hot on the selected slave, so ready from others drops out.
  assign w_sel_ready = (r_state == ST_ACCESS) && (|(i_s_ready & r_s_valid));

  always_comb begin
    w_sel_rdata = '0;
    for (int i = 0; i < NSLAVES; i++) begin
      if (r_sel == IDX_W'(i)) w_sel_rdata = i_s_rdata[32*i +: 32];
    end
  end

`ifdef PICOSOC_BUS_TIMEOUT_EN
  logic [15:0] r_tmo_cnt;

  always_ff @(posedge i_clk) begin
    if (i_reset)                    r_tmo_cnt <= '0;
    else if (r_state == ST_IDLE)    r_tmo_cnt <= '0;
    else if (r_state == ST_ACCESS)  r_tmo_cnt <= r_tmo_cnt + 16'd1;
  end

  // Fires on the TIMEOUT_CYCLES-th ACCESS cycle; a same-cycle s_ready wins.
  assign w_tmo = (r_state == ST_ACCESS) && !w_sel_ready &&
                 ((r_tmo_cnt + 16'd1) == 16'(TIMEOUT_CYCLES));
`else
  assign w_tmo = 1'b0;
`endif

  assign w_err_raise = ((r_state == ST_IDLE) && i_m_valid && w_miss) || w_tmo;
  assign w_err_addr  = w_tmo ? r_s_addr : i_m_addr;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= ST_IDLE;
      r_m_ready   <= 1'b0;
      r_m_rdata   <= '0;
      r_s_valid   <= '0;
      r_s_addr    <= '0;
      r_s_wdata   <= '0;
      r_s_wstrb   <= '0;
      r_sel       <= '0;
      r_miss_hold <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_m_ready <= 1'b0;
          if (i_m_valid) begin
            r_s_addr  <= i_m_addr;
            r_s_wdata <= i_m_wdata;
            r_s_wstrb <= i_m_wstrb;
            r_sel     <= w_idx;
            if (w_miss) begin
              r_state     <= ST_RESP;
              r_m_rdata   <= ERR_RDATA;
              r_miss_hold <= 1'b1;
            end else begin
              r_state   <= ST_ACCESS;
              r_s_valid <= w_hit;
            end
          end
        end
        ST_ACCESS: begin
          if (w_sel_ready) begin
            r_state   <= ST_RESP;
            r_s_valid <= '0;
            r_m_rdata <= w_sel_rdata;
            r_m_ready <= 1'b1;
          end else if (w_tmo) begin
            r_state   <= ST_RESP;
            r_s_valid <= '0;
            r_m_rdata <= ERR_RDATA;
            r_m_ready <= 1'b1;
          end
        end
        ST_RESP: begin
          // A miss waits one cycle so its m_ready lands where a hit's would.
          if (r_miss_hold) begin
            r_miss_hold <= 1'b0;
            r_m_ready   <= 1'b1;
          end else begin
            r_m_ready <= 1'b0;
            r_state   <= ST_IDLE;
          end
        end
        default: begin
          r_state   <= ST_IDLE;
          r_m_ready <= 1'b0;
          r_s_valid <= '0;
        end
      endcase
    end
  end

  // First error is kept until cleared; clear and new error together re-arm.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_err_valid <= 1'b0;
      r_err_addr  <= '0;
    end else if (w_err_raise) begin
      if (!r_err_valid || i_err_clr) begin
        r_err_valid <= 1'b1;
        r_err_addr  <= w_err_addr;
      end
    end else if (i_err_clr) begin
      r_err_valid <= 1'b0;
    end
  end

  assign o_m_ready   = r_m_ready;
  assign o_m_rdata   = r_m_rdata;
  assign o_s_valid   = r_s_valid;
  assign o_s_addr    = r_s_addr;
  assign o_s_wdata   = r_s_wdata;
  assign o_s_wstrb   = r_s_wstrb;
  assign o_err_valid = r_err_valid;
  assign o_err_addr  = r_err_addr;

endmodule

// File: tb/tb_picosoc_bus.sv
// Directed bench for picosoc_bus: vector table plus back-to-back, error-clear and reset sequences.
// Timeout vectors are included when PICOSOC_BUS_TIMEOUT_EN is defined.
module tb_picosoc_bus;
  localparam int NS = 4;
`ifdef PICOSOC_BUS_TIMEOUT_EN
  localparam int TMO = 8;
`else
  localparam int TMO = 255;
`endif

  logic            clk = 1'b0;
  logic            reset;
  logic            m_valid, m_ready;
  logic [31:0]     m_addr, m_wdata, m_rdata;
  logic [3:0]      m_wstrb;
  logic [NS-1:0]   s_valid, s_ready;
  logic [31:0]     s_addr, s_wdata;
  logic [3:0]      s_wstrb;
  logic [NS*32-1:0] s_rdata;
  logic            err_valid, err_clr;
  logic [31:0]     err_addr;

  logic [31:0]     slv_rd [NS];
  int              acc_cnt = 0;
  int              cur_delay = 0;
  logic [NS-1:0]   mute = '0;
  logic [NS-1:0]   noise = '0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  picosoc_bus #(.NSLAVES(NS), .TIMEOUT_CYCLES(TMO)) dut (
    .i_clk(clk), .i_reset(reset),
    .i_m_valid(m_valid), .o_m_ready(m_ready),
    .i_m_addr(m_addr), .i_m_wdata(m_wdata), .i_m_wstrb(m_wstrb), .o_m_rdata(m_rdata),
    .o_s_valid(s_valid), .i_s_ready(s_ready),
    .o_s_addr(s_addr), .o_s_wdata(s_wdata), .o_s_wstrb(s_wstrb),
    .i_s_rdata(s_rdata),
    .o_err_valid(err_valid), .o_err_addr(err_addr), .i_err_clr(err_clr)
  );

  // Slave model: ready after cur_delay waiting cycles, muted slaves never answer.
  assign s_rdata = {slv_rd[3], slv_rd[2], slv_rd[1], slv_rd[0]};
  always_comb s_ready = ((acc_cnt == cur_delay) ? (s_valid & ~mute) : '0) | noise;
  always @(posedge clk) begin
    if ((|s_valid) && !(|(s_ready & s_valid))) acc_cnt <= acc_cnt + 1;
    else acc_cnt <= 0;
  end

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] rd;
    int          delay;
    logic [3:0]  mute;
    logic [3:0]  noise;
    bit          clr;
    logic [3:0]  exp_sv;
    int          exp_svc;
    int          exp_lat;
    logic [31:0] exp_rdata;
    bit          exp_err;
    logic [31:0] exp_eaddr;
  } vec_t;

  vec_t vecs[$];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_vec(input string tag, input vec_t v);
    int cyc;
    int svc;
    logic [3:0] sv_seen;
    bit got;
    if (v.clr) begin
      err_clr = 1'b1;
      step();
      err_clr = 1'b0;
      step();
      chk({tag, "_errclr"}, 32'(err_valid), 32'd0);
    end
    for (int i = 0; i < NS; i++) slv_rd[i] = v.exp_sv[i] ? v.rd : (32'hBAD0_0000 | 32'(i));
    cur_delay = v.delay;
    mute      = v.mute;
    noise     = v.noise;
    m_addr    = v.addr;
    m_wdata   = v.wdata;
    m_wstrb   = v.wstrb;
    m_valid   = 1'b1;
    cyc = 0; svc = 0; sv_seen = '0; got = 1'b0;
    while (!got && cyc < 40) begin
      step();
      cyc++;
      m_valid = 1'b0;
      if (cyc == 1) begin
        chk({tag, "_saddr"},  s_addr, v.addr);
        chk({tag, "_swdata"}, s_wdata, v.wdata);
        chk({tag, "_swstrb"}, 32'(s_wstrb), 32'(v.wstrb));
      end
      if (|s_valid) svc++;
      sv_seen |= s_valid;
      if (m_ready) got = 1'b1;
    end
    chk({tag, "_latency"}, 32'(cyc), 32'(v.exp_lat));
    chk({tag, "_svalid"},  32'(sv_seen), 32'(v.exp_sv));
    chk({tag, "_svcyc"},   32'(svc), 32'(v.exp_svc));
    chk({tag, "_rdata"},   m_rdata, v.exp_rdata);
    chk({tag, "_errv"},    32'(err_valid), 32'(v.exp_err));
    if (v.exp_err) chk({tag, "_erra"}, err_addr, v.exp_eaddr);
    step();
    chk({tag, "_mready_off"}, 32'(m_ready), 32'd0);
    chk({tag, "_rdata_hold"}, m_rdata, v.exp_rdata);
    noise = '0;
    mute  = '0;
  endtask

  initial begin
    int nrdy;
    reset = 1'b1; m_valid = 1'b0; m_addr = '0; m_wdata = '0; m_wstrb = '0; err_clr = 1'b0;
    for (int i = 0; i < NS; i++) slv_rd[i] = '0;

    //            addr          wdata         wstrb    rd            dly mute     noise    clr  sv       svc lat rdata         err eaddr
    vecs.push_back('{32'h0100_0010, 32'h0,        4'b0000, 32'h1234_5678, 0, 4'b0000, 4'b0000, 1, 4'b0010, 1, 2, 32'h1234_5678, 0, 32'h0});
    vecs.push_back('{32'h0300_0000, 32'hA5A5_0001, 4'b0011, 32'h0000_0033, 5, 4'b0000, 4'b0000, 1, 4'b1000, 6, 7, 32'h0000_0033, 0, 32'h0});
    vecs.push_back('{32'h0700_0000, 32'h0,        4'b0000, 32'h5555_5555, 0, 4'b0000, 4'b0000, 1, 4'b0000, 0, 2, 32'hDEAD_BEEF, 1, 32'h0700_0000});
    vecs.push_back('{32'h0000_FFFC, 32'h0,        4'b0000, 32'h0BAD_CAFE, 2, 4'b0000, 4'b0100, 1, 4'b0001, 3, 4, 32'h0BAD_CAFE, 0, 32'h0});
    vecs.push_back('{32'h0200_1234, 32'h0,        4'b0000, 32'h2222_0000, 1, 4'b0000, 4'b0000, 1, 4'b0100, 2, 3, 32'h2222_0000, 0, 32'h0});
    vecs.push_back('{32'h03FF_FFFF, 32'hCAFE_F00D, 4'b1111, 32'h3333_3333, 0, 4'b0000, 4'b0000, 1, 4'b1000, 1, 2, 32'h3333_3333, 0, 32'h0});
    vecs.push_back('{32'h0400_0000, 32'h0,        4'b0001, 32'h0,         0, 4'b0000, 4'b0000, 1, 4'b0000, 0, 2, 32'hDEAD_BEEF, 1, 32'h0400_0000});
    vecs.push_back('{32'hFF00_0000, 32'h0,        4'b0000, 32'h0,         0, 4'b0000, 4'b0000, 0, 4'b0000, 0, 2, 32'hDEAD_BEEF, 1, 32'h0400_0000});
    vecs.push_back('{32'h00FF_FFFF, 32'h0,        4'b0000, 32'h0000_0001, 0, 4'b0000, 4'b0000, 0, 4'b0001, 1, 2, 32'h0000_0001, 1, 32'h0400_0000});
`ifdef PICOSOC_BUS_TIMEOUT_EN
    vecs.push_back('{32'h0200_0000, 32'h0,        4'b0000, 32'h6666_6666, 0, 4'b0100, 4'b0000, 1, 4'b0100, 8, 9, 32'hDEAD_BEEF, 1, 32'h0200_0000});
    vecs.push_back('{32'h0200_0040, 32'h0,        4'b0000, 32'h6666_6666, 0, 4'b0100, 4'b0000, 0, 4'b0100, 8, 9, 32'hDEAD_BEEF, 1, 32'h0200_0000});
    vecs.push_back('{32'h0200_0080, 32'h0,        4'b0000, 32'h7777_7777, 7, 4'b0000, 4'b0000, 1, 4'b0100, 8, 9, 32'h7777_7777, 0, 32'h0});
`endif

    repeat (3) step();
    chk("rst_mready", 32'(m_ready), 32'd0);
    chk("rst_mrdata", m_rdata, 32'd0);
    chk("rst_svalid", 32'(s_valid), 32'd0);
    chk("rst_saddr",  s_addr, 32'd0);
    chk("rst_swdata", s_wdata, 32'd0);
    chk("rst_swstrb", 32'(s_wstrb), 32'd0);
    chk("rst_errv",   32'(err_valid), 32'd0);
    chk("rst_erra",   err_addr, 32'd0);
    reset = 1'b0;
    step();

    foreach (vecs[k]) run_vec($sformatf("v%0d", k), vecs[k]);

    // Back-to-back: m_valid held high through the first completion.
    slv_rd[2] = 32'h2B2B_0002; slv_rd[3] = 32'h3C3C_0003; cur_delay = 0;
    m_addr = 32'h0200_0000; m_wstrb = 4'b0000; m_valid = 1'b1;
    step();
    chk("b2b_sv1", 32'(s_valid), 32'h4);
    step();
    chk("b2b_rdy1", 32'(m_ready), 32'd1);
    chk("b2b_rd1", m_rdata, 32'h2B2B_0002);
    m_addr = 32'h0300_0004;
    step();
    chk("b2b_idle_rdy", 32'(m_ready), 32'd0);
    chk("b2b_idle_sv", 32'(s_valid), 32'd0);
    step();
    m_valid = 1'b0;
    chk("b2b_sv2", 32'(s_valid), 32'h8);
    chk("b2b_saddr2", s_addr, 32'h0300_0004);
    step();
    chk("b2b_rdy2", 32'(m_ready), 32'd1);
    chk("b2b_rd2", m_rdata, 32'h3C3C_0003);
    step();

    // Clear coinciding with a new error leaves the flag set with the new address.
    run_vec("pre_clr", '{32'h0500_0000, 32'h0, 4'b0000, 32'h0, 0, 4'b0000, 4'b0000, 1, 4'b0000, 0, 2, 32'hDEAD_BEEF, 1, 32'h0500_0000});
    m_addr = 32'h0600_0000; m_valid = 1'b1; err_clr = 1'b1;
    step();
    m_valid = 1'b0; err_clr = 1'b0;
    chk("simclr_errv", 32'(err_valid), 32'd1);
    chk("simclr_erra", err_addr, 32'h0600_0000);
    step(); step();
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("clr_errv", 32'(err_valid), 32'd0);

    // Reset in the middle of a stalled access.
    mute = 4'b0010; m_addr = 32'h0100_0000; m_valid = 1'b1;
    step();
    m_valid = 1'b0;
    chk("rstacc_sv", 32'(s_valid), 32'h2);
    step(); step();
    reset = 1'b1;
    step();
    chk("rstacc_sv_off", 32'(s_valid), 32'd0);
    chk("rstacc_rdy", 32'(m_ready), 32'd0);
    reset = 1'b0; mute = '0;
    nrdy = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (m_ready) nrdy++;
    end
    chk("rstacc_no_rdy", 32'(nrdy), 32'd0);
    run_vec("post_rst", '{32'h0100_0010, 32'h0, 4'b0000, 32'h1234_5678, 0, 4'b0000, 4'b0000, 0, 4'b0010, 1, 2, 32'h1234_5678, 0, 32'h0});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
